// File: rtl/seq_detect_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : seq_detect_pkg
//  Purpose  : Shared types and default constants for the seq_detect_arbiter
//             slice: FSM state encoding, default word/pattern geometry and the
//             requester-id type.
//  Revision : 1.0  initial release
// ============================================================================
package seq_detect_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_e;

   localparam int                   DEF_WORD_W  = 8;
   localparam int                   DEF_PAT_W   = 4;
   localparam logic [DEF_PAT_W-1:0] DEF_PATTERN = 4'b1101;

   // Requester index: 0 or 1.
   typedef logic req_id_t;

endpackage
`default_nettype wire

// File: rtl/seq_detect_arbiter_pattern_window.sv
`default_nettype none
// ============================================================================
//  Module   : pattern_window
//  Purpose  : Sliding PAT_W-bit window over a serial bit stream. The newest bit
//             enters at the LSB, so the oldest bit sits at the window MSB.
//             A fill counter suppresses matches until the window holds PAT_W
//             valid bits of the current word.
//  Ports    : clk      - rising-edge clock
//             rst      - asynchronous active-low reset
//             clr      - synchronous clear of window and fill count
//             shift_en - shift bit_in into the window this cycle
//             bit_in   - serial input bit
//             match    - combinational: this cycle's shift completes PATTERN
//  Revision : 1.0  initial release
// ============================================================================
module pattern_window
   import seq_detect_pkg::*;
#(
   parameter int               PAT_W   = DEF_PAT_W,
   parameter logic [PAT_W-1:0] PATTERN = DEF_PATTERN
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic shift_en,
   input  logic bit_in,
   output logic match
);

   localparam int FILL_W = $clog2(PAT_W + 1);

   logic [PAT_W-1:0]  win_q;
   logic [FILL_W-1:0] fill_q;
   logic [PAT_W-1:0]  win_d;
   logic [FILL_W-1:0] fill_d;

   // Match is judged on the window as it will look after this shift.
   always_comb begin
      win_d  = {win_q[PAT_W-2:0], bit_in};
      fill_d = (fill_q == FILL_W'(PAT_W)) ? fill_q : fill_q + FILL_W'(1);
   end

   assign match = shift_en && (fill_d == FILL_W'(PAT_W)) && (win_d == PATTERN);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         win_q  <= '0;
         fill_q <= '0;
      end else if (clr) begin
         win_q  <= '0;
         fill_q <= '0;
      end else if (shift_en) begin
         win_q  <= win_d;
         fill_q <= fill_d;
      end
   end

endmodule
`default_nettype wire

// File: rtl/seq_detect_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : seq_detect_arbiter
//  Purpose  : Round-robin shares one serial pattern detector between two
//             word requesters. An accepted word is shifted MSB-first through
//             the window, one bit per clock; matches are counted and a
//             one-cycle result tagged with the requester id is returned.
//  Ports    : clk, rst (async active-low)
//             req{0,1}_valid/_data/_ready - word handshake per requester
//             res_valid/res_id/res_count/res_hit - one-cycle result strobe
//             ser_bit/ser_z - last shifted bit and its match flag
//             busy - FSM not idle
//             total_matches - saturating match accumulator (only when
//                             SEQ_DETECT_TOTAL_EN is defined)
//  Revision : 1.0  initial release
// ============================================================================
module seq_detect_arbiter
   import seq_detect_pkg::*;
#(
   parameter  int               WORD_W  = DEF_WORD_W,
   parameter  int               PAT_W   = DEF_PAT_W,
   parameter  logic [PAT_W-1:0] PATTERN = DEF_PATTERN,
   localparam int               CNT_W   = $clog2(WORD_W + 1)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req0_valid,
   input  logic [WORD_W-1:0] req0_data,
   output logic              req0_ready,
   input  logic              req1_valid,
   input  logic [WORD_W-1:0] req1_data,
   output logic              req1_ready,
   output logic              res_valid,
   output logic              res_id,
   output logic [CNT_W-1:0]  res_count,
   output logic              res_hit,
   output logic              ser_bit,
   output logic              ser_z,
`ifdef SEQ_DETECT_TOTAL_EN
   output logic [15:0]       total_matches,
`endif
   output logic              busy
);

   state_e            state_q;
   req_id_t           last_grant_q;
   req_id_t           id_q;
   logic [WORD_W-1:0] shreg_q;
   logic [CNT_W-1:0]  bitcnt_q;
   logic [CNT_W-1:0]  cnt_q;
   logic              res_valid_q;
   req_id_t           res_id_q;
   logic [CNT_W-1:0]  res_count_q;
   logic              res_hit_q;
   logic              ser_bit_q;
   logic              ser_z_q;

   req_id_t           grant_d;
   logic              idle;
   logic              accept;
   logic              shift_en;
   logic              shift_bit;
   logic              match;
   logic [WORD_W-1:0] word_d;

   // Round-robin: a lone requester wins; on a tie the one not served last.
   always_comb begin
      if (req0_valid && req1_valid) begin
         grant_d = ~last_grant_q;
      end else if (req1_valid) begin
         grant_d = 1'b1;
      end else begin
         grant_d = 1'b0;
      end
   end

   assign idle       = (state_q == IDLE);
   // Gated by rst so both readys drop the instant reset asserts.
   assign req0_ready = rst && idle && req0_valid && !grant_d;
   assign req1_ready = rst && idle && req1_valid &&  grant_d;
   assign accept     = req0_ready || req1_ready;
   assign word_d     = grant_d ? req1_data : req0_data;
   assign shift_en   = (state_q == SHIFT);
   assign shift_bit  = shreg_q[WORD_W-1];

   pattern_window #(
      .PAT_W   (PAT_W),
      .PATTERN (PATTERN)
   ) u_window (
      .clk      (clk),
      .rst      (rst),
      .clr      (accept),
      .shift_en (shift_en),
      .bit_in   (shift_bit),
      .match    (match)
   );

`ifdef SEQ_DETECT_TOTAL_EN
   logic [15:0] total_q;
   logic [16:0] total_sum;
   assign total_sum     = {1'b0, total_q} + 17'(cnt_q);
   assign total_matches = total_q;
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= IDLE;
         last_grant_q <= 1'b1;
         id_q         <= 1'b0;
         shreg_q      <= '0;
         bitcnt_q     <= '0;
         cnt_q        <= '0;
         res_valid_q  <= 1'b0;
         res_id_q     <= 1'b0;
         res_count_q  <= '0;
         res_hit_q    <= 1'b0;
         ser_bit_q    <= 1'b0;
         ser_z_q      <= 1'b0;
`ifdef SEQ_DETECT_TOTAL_EN
         total_q      <= '0;
`endif
      end else begin
         res_valid_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (accept) begin
                  shreg_q      <= word_d;
                  id_q         <= grant_d;
                  last_grant_q <= grant_d;
                  cnt_q        <= '0;
                  bitcnt_q     <= CNT_W'(WORD_W);
                  state_q      <= SHIFT;
               end
            end
            SHIFT: begin
               shreg_q   <= {shreg_q[WORD_W-2:0], 1'b0};
               ser_bit_q <= shift_bit;
               ser_z_q   <= match;
               if (match) begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
               bitcnt_q <= bitcnt_q - CNT_W'(1);
               if (bitcnt_q == CNT_W'(1)) begin
                  state_q <= DONE;
               end
            end
            DONE: begin
               res_valid_q <= 1'b1;
               res_id_q    <= id_q;
               res_count_q <= cnt_q;
               res_hit_q   <= (cnt_q != '0);
               ser_z_q     <= 1'b0;
`ifdef SEQ_DETECT_TOTAL_EN
               total_q     <= total_sum[16] ? 16'hFFFF : total_sum[15:0];
`endif
               state_q     <= IDLE;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign res_valid = res_valid_q;
   assign res_id    = res_id_q;
   assign res_count = res_count_q;
   assign res_hit   = res_hit_q;
   assign ser_bit   = ser_bit_q;
   assign ser_z     = ser_z_q;
   assign busy      = !idle;

endmodule
`default_nettype wire

// File: tb/tb_seq_detect_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_seq_detect_arbiter
//  Purpose  : Scoreboard bench for seq_detect_arbiter. A cycle-level model
//             predicts grants, readys and busy, pushes the expected serial
//             bits and result of every accepted word into queues, and a
//             monitor pops and compares them as the DUT presents them.
//  Revision : 1.0  initial release
// ============================================================================
module tb_seq_detect_arbiter;

   localparam int               WORD_W  = 8;
   localparam int               PAT_W   = 4;
   localparam logic [PAT_W-1:0] PATTERN = 4'b1101;
   localparam int               CNT_W   = $clog2(WORD_W + 1);

   logic              clk = 1'b0;
   logic              rst = 1'b0;
   logic              drv_v0 = 1'b0, drv_v1 = 1'b0;
   logic [WORD_W-1:0] drv_d0 = '0, drv_d1 = '0;
   logic              req0_ready, req1_ready;
   logic              res_valid, res_id, res_hit, ser_bit, ser_z, busy;
   logic [CNT_W-1:0]  res_count;
`ifdef SEQ_DETECT_TOTAL_EN
   logic [15:0]       total_matches;
   int                m_total = 0;
`endif

   seq_detect_arbiter #(
      .WORD_W  (WORD_W),
      .PAT_W   (PAT_W),
      .PATTERN (PATTERN)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .req0_valid    (drv_v0),
      .req0_data     (drv_d0),
      .req0_ready    (req0_ready),
      .req1_valid    (drv_v1),
      .req1_data     (drv_d1),
      .req1_ready    (req1_ready),
      .res_valid     (res_valid),
      .res_id        (res_id),
      .res_count     (res_count),
      .res_hit       (res_hit),
      .ser_bit       (ser_bit),
      .ser_z         (ser_z),
`ifdef SEQ_DETECT_TOTAL_EN
      .total_matches (total_matches),
`endif
      .busy          (busy)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct { int cyc; logic id; int cnt; } res_t;
   typedef struct { int cyc; logic b; logic z; } ser_t;
   res_t res_q[$];
   ser_t ser_q[$];

   logic m_last      = 1'b1;
   int   m_next_idle = 0;
   int   m_acc       = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference: slide a PAT_W slice over the word, oldest bit = word MSB side.
   function automatic int ref_count(input logic [WORD_W-1:0] w, output logic [WORD_W-1:0] zmask);
      int               n = 0;
      logic [PAT_W-1:0] win;
      zmask = '0;
      for (int k = PAT_W; k <= WORD_W; k++) begin
         win = w[WORD_W-k +: PAT_W];
         if (win == PATTERN) begin
            n++;
            zmask[k-1] = 1'b1;
         end
      end
      return n;
   endfunction

   task automatic push_word(input logic id, input logic [WORD_W-1:0] w, input int acc_edge);
      logic [WORD_W-1:0] zm;
      int                n;
      ser_t              s;
      res_t              r;
      n = ref_count(w, zm);
      for (int k = 1; k <= WORD_W; k++) begin
         s.cyc = acc_edge + k;
         s.b   = w[WORD_W-k];
         s.z   = zm[k-1];
         ser_q.push_back(s);
      end
      r.cyc = acc_edge + WORD_W + 1;
      r.id  = id;
      r.cnt = n;
      res_q.push_back(r);
   endtask

   // Model + monitor, evaluated mid-cycle on the falling edge.
   always @(negedge clk) begin
      logic e0, e1, g, exp_busy, exp_rv;
      ser_t s;
      res_t r;
      if (!rst) begin
         chk("ready0_in_reset", req0_ready, 0);
         chk("ready1_in_reset", req1_ready, 0);
         chk("res_valid_in_reset", res_valid, 0);
      end else begin
         exp_busy = (cyc < m_next_idle);
         e0 = 1'b0;
         e1 = 1'b0;
         g  = 1'b0;
         if (!exp_busy) begin
            if (drv_v0 && drv_v1) g = !m_last;
            else                  g = drv_v1;
            e0 = drv_v0 && !g;
            e1 = drv_v1 &&  g;
         end
         chk("busy", busy, exp_busy);
         chk("req0_ready", req0_ready, e0);
         chk("req1_ready", req1_ready, e1);
         if (e0 || e1) begin
            push_word(g, g ? drv_d1 : drv_d0, cyc + 1);
            m_last      = g;
            m_next_idle = cyc + 1 + WORD_W + 1;
            m_acc++;
         end
         if (ser_q.size() > 0 && ser_q[0].cyc == cyc) begin
            s = ser_q.pop_front();
            chk("ser_bit", ser_bit, s.b);
            chk("ser_z", ser_z, s.z);
         end else begin
            chk("ser_z_quiet", ser_z, 0);
         end
         exp_rv = (res_q.size() > 0) && (res_q[0].cyc == cyc);
         chk("res_valid", res_valid, exp_rv);
         if (exp_rv) begin
            r = res_q.pop_front();
            chk("res_id", res_id, r.id);
            chk("res_count", res_count, r.cnt);
            chk("res_hit", res_hit, r.cnt != 0);
`ifdef SEQ_DETECT_TOTAL_EN
            m_total = (m_total + r.cnt > 65535) ? 65535 : m_total + r.cnt;
            chk("total_matches", total_matches, m_total);
`endif
         end
      end
   end

   task automatic check_zero();
      chk("rst_busy", busy, 0);
      chk("rst_ready0", req0_ready, 0);
      chk("rst_ready1", req1_ready, 0);
      chk("rst_res_valid", res_valid, 0);
      chk("rst_res_id", res_id, 0);
      chk("rst_res_count", res_count, 0);
      chk("rst_res_hit", res_hit, 0);
      chk("rst_ser_bit", ser_bit, 0);
      chk("rst_ser_z", ser_z, 0);
`ifdef SEQ_DETECT_TOTAL_EN
      chk("rst_total", total_matches, 0);
`endif
   endtask

   // Called shortly after a rising edge; drops everything in flight.
   task automatic pulse_reset();
      rst = 1'b0;
      ser_q.delete();
      res_q.delete();
      m_last      = 1'b1;
      m_next_idle = 0;
`ifdef SEQ_DETECT_TOTAL_EN
      m_total     = 0;
`endif
      #1;
      check_zero();
      repeat (2) @(posedge clk);
      #2 rst = 1'b1;
   endtask

   task automatic send(input logic id, input logic [WORD_W-1:0] d);
      int start;
      start = m_acc;
      @(posedge clk); #1;
      if (id) begin drv_v1 = 1'b1; drv_d1 = d; end
      else    begin drv_v0 = 1'b1; drv_d0 = d; end
      for (int i = 0; i < 60 && m_acc == start; i++) @(posedge clk);
      chk("accept_timeout", m_acc, start + 1);
      #1;
      drv_v0 = 1'b0;
      drv_v1 = 1'b0;
   endtask

   task automatic drain();
      for (int i = 0; i < 40 && (res_q.size() != 0 || cyc < m_next_idle); i++) @(posedge clk);
      chk("drain_timeout", res_q.size(), 0);
   endtask

   logic [WORD_W-1:0] tbl [6] = '{8'hDA, 8'hDD, 8'h6D, 8'hFF, 8'h00, 8'hB6};

   initial begin
      #12;
      check_zero();
      @(posedge clk); #2 rst = 1'b1;

      // Both requesters valid straight after reset: grants must alternate 0,1,0,1.
      @(posedge clk); #1;
      drv_v0 = 1'b1; drv_d0 = 8'b1101_1101;
      drv_v1 = 1'b1; drv_d1 = 8'b1011_0110;
      repeat (45) @(posedge clk);
      #1 drv_v0 = 1'b0; drv_v1 = 1'b0;
      drain();

      send(1'b0, 8'b1101_1010); drain();
      send(1'b1, 8'b0000_0000); drain();
      send(1'b0, 8'b0000_0110);
      send(1'b0, 8'b1000_0000); drain();

      // Reset in the third SHIFT cycle, then a fresh word from requester 1.
      send(1'b0, 8'hFF);
      repeat (2) @(posedge clk);
      #1 pulse_reset();
      send(1'b1, 8'b0110_1000); drain();

      // Randomized traffic with one reset in the middle.
      for (int i = 0; i < 800; i++) begin
         @(posedge clk); #1;
         if (i == 400) pulse_reset();
         drv_v0 = ($urandom_range(0, 2) != 0);
         drv_v1 = ($urandom_range(0, 2) != 0);
         drv_d0 = ($urandom_range(0, 1) != 0) ? tbl[$urandom_range(0, 5)] : WORD_W'($urandom);
         drv_d1 = ($urandom_range(0, 1) != 0) ? tbl[$urandom_range(0, 5)] : WORD_W'($urandom);
      end
      #1 drv_v0 = 1'b0; drv_v1 = 1'b0;
      drain();

      chk("results_left", res_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
